// File: rtl/mem_sys_pkg.sv
// Shared types for the memory subsystem: FSM states, port-select encoding, wait bound.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_e;

    // Largest supported WAIT_STATES value; sizes the wait counter.
    localparam int WAIT_STATES_MAX = 7;
    localparam int CNT_W           = 3;

endpackage

// File: rtl/mem_subsystem_if.sv
// Instruction and data request/response bundle for the shared memory.
// Latency: n/a (wires only).
// Backpressure: requesters hold *_req until the matching *_ready pulse.
interface mem_subsystem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ready;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;
    logic                  d_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  i_rdata, i_ready, i_err, d_rdata, d_ready, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_rdata, i_ready, i_err, d_rdata, d_ready, d_err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage with byte-enabled synchronous write and registered read.
// Latency: write and read both take effect at the clock edge where the strobe is high.
// Backpressure: none; the caller strobes at most one of we_i/re_i per cycle.
module mem_array #(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS),
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Byte-enabled write; storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register captures the addressed word on the read strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_subsystem.sv
// Arbitrates instruction and data ports onto one word array via an IDLE/WAIT/RESP FSM.
// Latency: ready pulses WAIT_STATES+1 edges after the grant edge, then one idle bubble cycle.
// Backpressure: requests are held by the requester until ready; the losing port simply waits.
module mem_subsystem
    import mem_sys_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           Clk,
    input  logic           Clr,
    mem_subsystem_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    port_sel_e           last_q, last_d;
    port_sel_e           sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                grant_i, grant_d;
    logic                commit;
    logic                misalign_d, misalign_q;
    logic                resp_rd_ok;
    logic [DATA_W-1:0]   arr_rdata;

    // Round-robin on collision: the port that did not win last time goes first.
    assign grant_i = bus.i_req && (!bus.d_req || (last_q == PORT_D));
    assign grant_d = bus.d_req && !grant_i;

    // Next-state, access latching and wait countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_i || grant_d) begin
                    sel_d   = grant_d ? PORT_D : PORT_I;
                    last_d  = sel_d;
                    addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                    we_d    = grant_d && bus.d_we;
                    be_d    = bus.d_be;
                    wdata_d = bus.d_wdata;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched access registers; reset aborts any access in flight.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= PORT_I;
            sel_q   <= PORT_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // The array is touched only on the edge entering RESP; the _d values cover the
    // zero-wait case where that edge is also the grant edge.
    assign misalign_d = |addr_d[OFF_W-1:0];
    assign misalign_q = |addr_q[OFF_W-1:0];
    assign commit     = !Clr && (state_d == ST_RESP) && (state_q != ST_RESP);

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem_array (
        .clk_i   (Clk),
        .rst_i   (Clr),
        .we_i    (commit && we_d && !misalign_d),
        .re_i    (commit && !we_d && !misalign_d),
        .idx_i   (addr_d[OFF_W +: IDX_W]),
        .be_i    (be_d),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    assign resp_rd_ok  = (state_q == ST_RESP) && !we_q && !misalign_q;

    assign bus.i_ready = (state_q == ST_RESP) && (sel_q == PORT_I);
    assign bus.d_ready = (state_q == ST_RESP) && (sel_q == PORT_D);
    assign bus.i_err   = bus.i_ready && misalign_q;
    assign bus.d_err   = bus.d_ready && misalign_q;
    assign bus.i_rdata = (bus.i_ready && resp_rd_ok) ? arr_rdata : '0;
    assign bus.d_rdata = (bus.d_ready && resp_rd_ok) ? arr_rdata : '0;
endmodule

// File: tb/tb_mem_subsystem.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-level memory model.
// Latency: expects ready WAIT_STATES+2 posedges after the request is first presented in IDLE.
// Backpressure: requests are held until ready, then dropped for one bubble cycle.
module tb_mem_subsystem;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WS = 2;
    localparam int EXP_LAT = WS + 2;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_subsystem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_subsystem #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH_WORDS (256),
        .WAIT_STATES (WS)
    ) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    // Reference memory: word contents plus per-byte "has been written" flags.
    logic [31:0] mem_m [256];
    logic [3:0]  kn_m  [256];

    task automatic model_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp_rd,
                                output logic [31:0] mask, output logic exp_err);
        int w;
        w       = int'(addr[9:2]);
        exp_err = (addr[1:0] != 2'b00);
        exp_rd  = 32'h0;
        mask    = 32'hFFFF_FFFF;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_m[w][b*8 +: 8] = wdata[b*8 +: 8];
                        kn_m[w][b] = 1'b1;
                    end
                end
            end else begin
                exp_rd = mem_m[w];
                for (int b = 0; b < 4; b++) mask[b*8 +: 8] = kn_m[w][b] ? 8'hFF : 8'h00;
            end
        end
    endtask

    // Runs one access starting at a negedge in IDLE; ends at a negedge in IDLE after the bubble.
    task automatic do_access(input bit port_d, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err, output int lat);
        bit other_seen;
        other_seen = 1'b0;
        lat = -1; rd = 32'h0; err = 1'b0;
        if (port_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (port_d ? bus.i_ready : bus.d_ready) other_seen = 1'b1;
            if (port_d ? bus.d_ready : bus.i_ready) begin
                lat = c;
                rd  = port_d ? bus.d_rdata : bus.i_rdata;
                err = port_d ? bus.d_err : bus.i_err;
                break;
            end
            // Request fields after the grant must be ignored.
            bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_be = 4'($urandom);
            bus.d_we = 1'($urandom); bus.i_addr = $urandom;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (other_seen) begin
            errors++; $display("FAIL other_port_ready: actual=1 required=0 (port_d=%0d)", port_d);
        end
        checks++;
        if ((bus.i_ready | bus.d_ready) !== 1'b0) begin
            errors++; $display("FAIL ready_single_pulse: actual=%b%b required=00", bus.i_ready, bus.d_ready);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.i_req = 1'b1; bus.i_addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: actual=%b required=0", bus.i_ready); end
        checks++;
        if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: actual=%b required=0", bus.d_ready); end
        checks++;
        if ({bus.i_err, bus.d_err} !== 2'b00) begin errors++; $display("FAIL reset_err: actual=%b%b required=00", bus.i_err, bus.d_err); end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: actual=%h/%h required=0", bus.i_rdata, bus.d_rdata); end
        bus.i_req = 1'b0; clr = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd, exp, mask; logic err, eerr; int lat;
        model_access(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, exp, mask, eerr);
        do_access(1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, rd, err, lat);
        checks++;
        if (lat != EXP_LAT) begin errors++; $display("FAIL wr_latency: actual=%0d required=%0d", lat, EXP_LAT); end
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wr_resp: rdata=%h err=%b required 0/0", rd, err); end
        model_access(1'b0, 4'h0, 32'h40, 32'h0, exp, mask, eerr);
        do_access(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, rd, err, lat);
        checks++;
        if (lat != EXP_LAT) begin errors++; $display("FAIL i_rd_latency: actual=%0d required=%0d", lat, EXP_LAT); end
        checks++;
        if (rd !== 32'hDEADBEEF || rd !== exp) begin errors++; $display("FAIL i_rd_data: actual=%h required=deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, exp, mask; logic err, eerr; int lat;
        model_access(1'b1, 4'b0011, 32'h40, 32'h12345678, exp, mask, eerr);
        do_access(1'b1, 1'b1, 4'b0011, 32'h40, 32'h12345678, rd, err, lat);
        model_access(1'b0, 4'h0, 32'h40, 32'h0, exp, mask, eerr);
        do_access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hDEAD5678 || rd !== exp) begin errors++; $display("FAIL byte_enable: actual=%h required=dead5678", rd); end
    endtask

    task automatic test_simultaneous();
        int d_at, i_at; logic [31:0] d_rd, i_rd, exp, mask; logic eerr;
        d_at = 0; i_at = 0; d_rd = 32'h0; i_rd = 32'h0;
        clr = 1'b1; #2; clr = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        for (int c = 1; c <= 16 && i_at == 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.d_ready && d_at == 0) begin d_at = c; d_rd = bus.d_rdata; bus.d_req = 1'b0; end
            if (bus.i_ready) begin i_at = c; i_rd = bus.i_rdata; bus.i_req = 1'b0; end
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        @(posedge clk); @(negedge clk);
        model_access(1'b0, 4'h0, 32'h40, 32'h0, exp, mask, eerr);
        checks++;
        if (d_at != EXP_LAT) begin errors++; $display("FAIL arb_d_first: d_ready posedge=%0d required=%0d", d_at, EXP_LAT); end
        checks++;
        if (i_at != EXP_LAT + 5) begin errors++; $display("FAIL arb_i_second: i_ready posedge=%0d required=%0d", i_at, EXP_LAT + 5); end
        checks++;
        if (d_rd !== exp || i_rd !== exp) begin errors++; $display("FAIL arb_data: d=%h i=%h required=%h", d_rd, i_rd, exp); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, exp, mask; logic err, eerr; int lat;
        do_access(1'b1, 1'b1, 4'hF, 32'h42, 32'hFFFF_FFFF, rd, err, lat);
        checks++;
        if (lat != EXP_LAT || err !== 1'b1) begin errors++; $display("FAIL misalign_wr: lat=%0d err=%b required %0d/1", lat, err, EXP_LAT); end
        do_access(1'b0, 1'b0, 4'h0, 32'h41, 32'h0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_rd: err=%b rdata=%h required 1/0", err, rd); end
        model_access(1'b0, 4'h0, 32'h40, 32'h0, exp, mask, eerr);
        do_access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hDEAD5678 || err !== 1'b0) begin errors++; $display("FAIL misalign_no_write: actual=%h err=%b required=dead5678/0", rd, err); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, exp, mask; logic err, eerr; int lat; bit seen;
        seen = 1'b0;
        model_access(1'b1, 4'hF, 32'h80, 32'h11111111, exp, mask, eerr);
        do_access(1'b1, 1'b1, 4'hF, 32'h80, 32'h11111111, rd, err, lat);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h80; bus.d_wdata = 32'h99999999;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        clr = 1'b1; bus.d_req = 1'b0;
        #2;
        if (bus.d_ready) seen = 1'b1;
        clr = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (bus.d_ready) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_ready: actual=1 required=0"); end
        model_access(1'b0, 4'h0, 32'h80, 32'h0, exp, mask, eerr);
        do_access(1'b1, 1'b0, 4'h0, 32'h80, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h11111111 || rd !== exp) begin errors++; $display("FAIL abort_no_write: actual=%h required=11111111", rd); end
        checks++;
        if (lat != EXP_LAT) begin errors++; $display("FAIL abort_next_latency: actual=%0d required=%0d", lat, EXP_LAT); end
    endtask

    task automatic test_alias();
        logic [31:0] rd, exp, mask; logic err, eerr; int lat;
        model_access(1'b1, 4'hF, 32'h0, 32'h0BADF00D, exp, mask, eerr);
        do_access(1'b1, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, rd, err, lat);
        model_access(1'b0, 4'h0, 32'h400, 32'h0, exp, mask, eerr);
        do_access(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0BADF00D || rd !== exp) begin errors++; $display("FAIL alias_read: actual=%h required=0badf00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, mask, addr, wd; logic err, eerr; int lat;
        bit pd, we; logic [3:0] be; int idx, lo;
        for (int n = 0; n < 80; n++) begin
            pd   = 1'($urandom_range(0, 1));
            we   = pd ? 1'($urandom_range(0, 1)) : 1'b0;
            be   = 4'($urandom);
            idx  = $urandom_range(0, 15) + 16;
            lo   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            addr = (32'($urandom_range(0, 7)) << 10) | (32'(idx) << 2) | 32'(lo);
            wd   = $urandom;
            model_access(we, be, addr, wd, exp, mask, eerr);
            do_access(pd, we, be, addr, wd, rd, err, lat);
            checks++;
            if (lat != EXP_LAT || err !== eerr || ((rd ^ exp) & mask) !== 32'h0) begin
                errors++;
                $display("FAIL random_op%0d: port_d=%0d we=%0d addr=%h lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h mask=%h",
                         n, pd, we, addr, lat, err, rd, EXP_LAT, eerr, exp, mask);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 256; w++) begin mem_m[w] = 32'h0; kn_m[w] = 4'h0; end
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_simultaneous();
        test_misaligned();
        test_reset_abort();
        test_alias();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
